mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one downstream memory port (val/rdy request and response channels) between p_num_clients upstream requesters, e.g. fetch unit and load/store unit.
- Round-robin arbitration on requests.
- Appends the client ID to the opaque field so responses route back; strips it on return.
- Enforces a per-client outstanding-request limit. Sits between the pipeline units and the memory/cache.

Parameters:
- p_num_clients, 2, number of upstream requesters (>=2).
- p_addr_bits, 32, address width.
- p_data_bits, 32, data width.
- p_opaq_bits, 8, client-side opaque width.
- p_max_in_flight, 4, max outstanding requests per client (>=1).
- Derived (localparam): ID_BITS = $clog2(p_num_clients); mem-side opaque width = p_opaq_bits+ID_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cli_req_val  in  N  per-client request valid
- cli_req_rdy  out  N  per-client request ready
- cli_req_msg  in  N*REQ_BITS  packed client request messages, client i at slice i
- cli_resp_val  out  N  per-client response valid
- cli_resp_rdy  in  N  per-client response ready
- cli_resp_msg  out  N*RESP_BITS  packed client responses (all slices carry the same stripped message)
- mem_req_val  out  1  downstream request valid
- mem_req_rdy  in  1  downstream request ready
- mem_req_msg  out  MREQ_BITS  downstream request, opaque widened by ID_BITS
- mem_resp_val  in  1  downstream response valid
- mem_resp_rdy  out  1  downstream response ready
- mem_resp_msg  in  MRESP_BITS  downstream response
- err_bad_id  out  1  one-cycle pulse: response carried ID >= N and was dropped

Behaviour:
- Message layout (package): {op(1: READ=0, WRITE=1), opaque, addr, len(2), data}. Response carries the same fields. The mem-side opaque is {client_id, client_opaque}, with the ID in the MSBs.
- Eligibility: elig[i] = cli_req_val[i] && (cnt[i] < p_max_in_flight).
- Grant, when unlocked: first eligible client scanning ptr, ptr+1, ... mod N.
  - Grant is computed from val and counters only, never from mem_req_rdy (no rdy->val combinational path).
- mem_req_val = |elig when unlocked; when locked, it stays 1 for the locked client.
- cli_req_rdy[i] = grant[i] && mem_req_rdy.
- mem_req_msg = granted client's message with its ID prepended to opaque.
- Grant lock:
  - If mem_req_val && !mem_req_rdy, register lock=1 and lock_id=grant.
  - Next cycle the grant is forced to lock_id regardless of ptr or other requests, so the downstream message stays stable.
  - Lock clears on the transfer.
  - A locked client is counted eligible even if its counter is full (the request was issued before the limit applied).
- Round-robin pointer: on each request transfer, ptr <= (granted id + 1) mod N. With no transfer, ptr holds.
- Counters: cnt[i] width $clog2(p_max_in_flight+1).
  - +1 on a request transfer from i; -1 on a response transfer to i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 saturates at 0.
- Response routing: rid = mem_resp opaque MSBs.
  - For rid < N: cli_resp_val[rid] = mem_resp_val, others 0; mem_resp_rdy = cli_resp_rdy[rid].
  - Response path is combinational, 0 cycles.
  - For rid >= N (non-power-of-2 N only): mem_resp_rdy = 1, no cli_resp_val asserted, err_bad_id = mem_resp_val (registered one-cycle pulse acceptable, 1-cycle latency).
- Request latency: 0 cycles combinational pass-through; no buffering.
- Reset: ptr=0, cnt all 0, lock=0, err_bad_id=0.
  - Reset mid-operation discards all tracking. Responses arriving after reset for pre-reset requests are still routed by ID; counters saturate at 0.

Decomposition:
- Package mem_arbiter_pkg: op encodings, field widths, packed request/response struct typedefs parameterised by opaque width, and a bit-width helper.
- Sub-module rr_arbiter (N-wide round-robin priority picker with ptr register and lock input), reusable elsewhere.
- Counters and routing stay in the top level.

Test Plan (N=2, max_in_flight=2):
- Both clients hold val with mem_req_rdy=1 for 4 cycles -> grants alternate 0,1,0,1; mem opaque MSB alternates 0,1.
- Client 0 requests addr 0x100 with mem_req_rdy=0 for 3 cycles while client 1 raises val in cycle 2 -> mem_req_msg stays addr 0x100/ID 0 until the transfer; client 1 is granted the next cycle.
- Client 0 issues 2 requests with no responses -> third request: cli_req_rdy[0]=0, mem_req_val=0. A response with opaque {1'b0,8'h05} returns -> cli_resp_val[0]=1 with opaque 8'h05; the next cycle client 0 is granted again.
- Response with ID 1 while cli_resp_rdy[1]=0 -> mem_resp_rdy=0 and cnt[1] unchanged; cli_resp_rdy[1]=1 -> transfer, cnt[1] decrements.
- Same-cycle request transfer and response transfer for client 0 at cnt=1 -> cnt stays 1.
- Assert rst with cnt[0]=2 and lock=1 -> next cycle cnt=0, lock=0, ptr=0; a client-1-only request is granted immediately.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory-port arbiter.
//   - op_e        : request/response operation encoding
//   - LEN_BITS    : width of the len field
//   - msg_bits()  : total packed width of a message for a given opaque width
//   - cli_msg_t / mem_msg_t : message layouts at the default widths
//     (32-bit addr/data, 8-bit client opaque, one ID bit). Modules with other
//     parameter values declare the same layout locally from their parameters.
// Message layout, MSB first: {op, opaque, addr, len, data}.
package mem_arbiter_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int OP_BITS  = 1;
    localparam int LEN_BITS = 2;

    function automatic int msg_bits(input int opaq_bits, input int addr_bits,
                                    input int data_bits);
        return OP_BITS + opaq_bits + addr_bits + LEN_BITS + data_bits;
    endfunction

    typedef struct packed {
        op_e            op;
        logic [7:0]     opaque;
        logic [31:0]    addr;
        logic [LEN_BITS-1:0] len;
        logic [31:0]    data;
    } cli_msg_t;

    // Memory-side opaque is {client_id, client_opaque}, ID in the MSBs.
    typedef struct packed {
        op_e            op;
        logic [0:0]     id;
        logic [7:0]     opaque;
        logic [31:0]    addr;
        logic [LEN_BITS-1:0] len;
        logic [31:0]    data;
    } mem_msg_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-wide round-robin priority picker.
//   clk, rst   : clock, synchronous active-high reset (ptr -> 0)
//   req        : per-requester eligibility
//   lock       : force the grant to lock_id (holds a stalled grant stable)
//   lock_id    : requester to grant while lock is set
//   advance    : the current grant was consumed; move ptr past it
//   grant_val  : some requester is granted
//   grant_id   : granted requester index
//   grant      : one-hot form of grant_id (all zero when grant_val is 0)
module rr_arbiter #(
    parameter  int p_num   = 2,
    localparam int ID_BITS = $clog2(p_num)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_num-1:0]   req,
    input  logic               lock,
    input  logic [ID_BITS-1:0] lock_id,
    input  logic               advance,
    output logic               grant_val,
    output logic [ID_BITS-1:0] grant_id,
    output logic [p_num-1:0]   grant
);

    logic [ID_BITS-1:0] ptr;
    logic [ID_BITS-1:0] cand;

    // Scan ptr, ptr+1, ... (mod p_num); the first eligible requester wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        grant_val = 1'b0;
        grant_id  = '0;
        cand      = '0;
        grant     = '0;
        if (lock) begin
            grant_val = 1'b1;
            grant_id  = lock_id;
        end else begin
            for (int k = 0; k < p_num; k++) begin
                cand = ID_BITS'((int'(ptr) + k) % p_num);
                if (!grant_val && req[cand]) begin
                    grant_val = 1'b1;
                    grant_id  = cand;
                end
            end
        end
        if (grant_val) grant[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values, independent of statement order.
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_id == ID_BITS'(p_num - 1)) ? '0 : grant_id + ID_BITS'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port among p_num_clients
// requesters with round-robin arbitration and a per-client in-flight limit.
//   clk, rst      : clock, synchronous active-high reset
//   cli_req_*     : per-client request channels (message i at slice i)
//   cli_resp_*    : per-client response channels (every slice carries the
//                   same message with the client ID stripped from opaque)
//   mem_req_*     : downstream request; opaque = {client_id, client_opaque}
//   mem_resp_*    : downstream response; routed back by the opaque ID bits
//   err_bad_id    : one-cycle pulse, a response carried ID >= p_num_clients
//                   and was dropped (only possible for non-power-of-2 N)
// Both paths are combinational pass-throughs; nothing is buffered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter  int p_num_clients   = 2,
    parameter  int p_addr_bits     = 32,
    parameter  int p_data_bits     = 32,
    parameter  int p_opaq_bits     = 8,
    parameter  int p_max_in_flight = 4,
    localparam int ID_BITS         = $clog2(p_num_clients),
    localparam int MOPAQ_BITS      = p_opaq_bits + ID_BITS,
    localparam int REQ_BITS        = msg_bits(p_opaq_bits, p_addr_bits, p_data_bits),
    localparam int RESP_BITS       = REQ_BITS,
    localparam int MREQ_BITS       = msg_bits(MOPAQ_BITS, p_addr_bits, p_data_bits),
    localparam int MRESP_BITS      = MREQ_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [p_num_clients-1:0]       cli_req_val,
    output logic [p_num_clients-1:0]       cli_req_rdy,
    input  logic [p_num_clients*REQ_BITS-1:0]  cli_req_msg,
    output logic [p_num_clients-1:0]       cli_resp_val,
    input  logic [p_num_clients-1:0]       cli_resp_rdy,
    output logic [p_num_clients*RESP_BITS-1:0] cli_resp_msg,
    output logic                           mem_req_val,
    input  logic                           mem_req_rdy,
    output logic [MREQ_BITS-1:0]           mem_req_msg,
    input  logic                           mem_resp_val,
    output logic                           mem_resp_rdy,
    input  logic [MRESP_BITS-1:0]          mem_resp_msg,
    output logic                           err_bad_id
);

    localparam int CNT_BITS = $clog2(p_max_in_flight + 1);

    typedef struct packed {
        op_e                    op;
        logic [p_opaq_bits-1:0] opaque;
        logic [p_addr_bits-1:0] addr;
        logic [LEN_BITS-1:0]    len;
        logic [p_data_bits-1:0] data;
    } cli_msg_t;

    typedef struct packed {
        op_e                    op;
        logic [ID_BITS-1:0]     id;
        logic [p_opaq_bits-1:0] opaque;
        logic [p_addr_bits-1:0] addr;
        logic [LEN_BITS-1:0]    len;
        logic [p_data_bits-1:0] data;
    } mem_msg_t;

    logic [CNT_BITS-1:0]      cnt [p_num_clients];
    logic                     lock;
    logic [ID_BITS-1:0]       lock_id;
    logic [p_num_clients-1:0] elig;
    logic [p_num_clients-1:0] grant;
    logic                     grant_val;
    logic [ID_BITS-1:0]       grant_id;
    logic                     req_xfer;
    logic [p_num_clients-1:0] resp_xfer;
    logic                     bad_id;
    logic [ID_BITS-1:0]       rid;
    cli_msg_t                 gmsg;
    cli_msg_t                 rstrip;
    mem_msg_t                 mresp;

    // ---------------- request side ----------------
    always_comb begin
        for (int i = 0; i < p_num_clients; i++) begin
            elig[i] = cli_req_val[i] && (cnt[i] < CNT_BITS'(p_max_in_flight));
        end
    end

    // The grant depends only on val and counters, never on mem_req_rdy.
    rr_arbiter #(.p_num(p_num_clients)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (elig),
        .lock      (lock),
        .lock_id   (lock_id),
        .advance   (req_xfer),
        .grant_val (grant_val),
        .grant_id  (grant_id),
        .grant     (grant)
    );

    assign mem_req_val = grant_val;
    assign req_xfer    = grant_val && mem_req_rdy;
    assign cli_req_rdy = grant & {p_num_clients{mem_req_rdy}};
    assign gmsg        = cli_msg_t'(cli_req_msg[int'(grant_id)*REQ_BITS +: REQ_BITS]);
    assign mem_req_msg = {gmsg.op, grant_id, gmsg.opaque, gmsg.addr, gmsg.len, gmsg.data};

    // A stalled grant is pinned to the same client until it transfers, so the
    // downstream message cannot change while mem_req_val is held high.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock    <= 1'b0;
            lock_id <= '0;
        end else begin
            lock <= grant_val && !mem_req_rdy;
            if (grant_val && !mem_req_rdy) lock_id <= grant_id;
        end
    end

    // ---------------- response side ----------------
    assign mresp  = mem_msg_t'(mem_resp_msg);
    assign rid    = mresp.id;
    assign rstrip = '{op: mresp.op, opaque: mresp.opaque, addr: mresp.addr,
                      len: mresp.len, data: mresp.data};
    assign cli_resp_msg = {p_num_clients{rstrip}};

    // Unused ID codes exist only when N is not a power of two.
    if ((2 ** ID_BITS) == p_num_clients) begin : g_id_full
        assign bad_id = 1'b0;
    end else begin : g_id_partial
        assign bad_id = (rid >= ID_BITS'(p_num_clients));
    end

    always_comb begin
        cli_resp_val = '0;
        mem_resp_rdy = 1'b1;      // bad IDs are accepted and dropped
        if (!bad_id) begin
            cli_resp_val[rid] = mem_resp_val;
            mem_resp_rdy      = cli_resp_rdy[rid];
        end
    end

    assign resp_xfer = cli_resp_val & cli_resp_rdy;

    always_ff @(posedge clk) begin
        if (rst) err_bad_id <= 1'b0;
        else     err_bad_id <= mem_resp_val && bad_id;
    end

    // ---------------- in-flight counters ----------------
    // Decrement saturates at 0 so responses to requests issued before a reset
    // cannot wrap a counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the counter array is architectural state and is cleared on
            // reset element by element; it is not a data RAM left undefined.
            for (int i = 0; i < p_num_clients; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < p_num_clients; i++) begin
                if (cli_req_rdy[i] && !resp_xfer[i]) begin
                    cnt[i] <= cnt[i] + CNT_BITS'(1);
                end else if (resp_xfer[i] && !cli_req_rdy[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tasks plus a randomized run checked
// against a behavioural model (N=2, max in flight 2, 8-bit client opaque).
module tb_mem_arbiter;

    localparam int RB = 75;   // client message bits
    localparam int MB = 76;   // memory message bits

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_val = '0;
    logic [1:0]      req_rdy;
    logic [2*RB-1:0] req_msg = '0;
    logic [1:0]      resp_val;
    logic [1:0]      resp_rdy = '0;
    logic [2*RB-1:0] resp_msg;
    logic            mem_req_val;
    logic            mem_req_rdy = 1'b0;
    logic [MB-1:0]   mem_req_msg;
    logic            mem_resp_val = 1'b0;
    logic            mem_resp_rdy;
    logic [MB-1:0]   mem_resp_msg = '0;
    logic            err_bad_id;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.p_num_clients(2), .p_addr_bits(32), .p_data_bits(32),
                  .p_opaq_bits(8), .p_max_in_flight(2)) dut (
        .clk(clk), .rst(rst),
        .cli_req_val(req_val), .cli_req_rdy(req_rdy), .cli_req_msg(req_msg),
        .cli_resp_val(resp_val), .cli_resp_rdy(resp_rdy), .cli_resp_msg(resp_msg),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
        .err_bad_id(err_bad_id)
    );

    always #5 clk = ~clk;

    function automatic logic [RB-1:0] mk_req(logic op, logic [7:0] opq, logic [31:0] addr,
                                             logic [1:0] len, logic [31:0] data);
        return {op, opq, addr, len, data};
    endfunction

    function automatic logic [MB-1:0] mk_mem(logic op, logic id, logic [7:0] opq,
                                             logic [31:0] addr, logic [1:0] len,
                                             logic [31:0] data);
        return {op, id, opq, addr, len, data};
    endfunction

    // Inputs change just after a falling edge; outputs are sampled 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_val = '0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0; resp_rdy = '0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        #1;
        checks++; if (err_bad_id !== 1'b0 || mem_req_val !== 1'b0 || resp_val !== 2'b00) begin
            errors++; $display("FAIL rst_outs: err=%b mval=%b rval=%b want 0/0/00",
                               err_bad_id, mem_req_val, resp_val); end
        rst = 1'b0;
        req_msg[0 +: RB]  = mk_req(1'b0, 8'h01, 32'h10, 2'd0, 32'h1);
        req_msg[RB +: RB] = mk_req(1'b1, 8'h02, 32'h20, 2'd1, 32'h2);
        req_val = 2'b11;
        #1;
        checks++; if (mem_req_val !== 1'b1 || mem_req_msg[74] !== 1'b0 || req_rdy !== 2'b00) begin
            errors++; $display("FAIL rst_ptr0: mval=%b id=%b rdy=%b want 1/0/00",
                               mem_req_val, mem_req_msg[74], req_rdy); end
        do_reset();
    endtask

    task automatic test_alternate();
        logic [MB-1:0] exp_m [2];
        logic [1:0] exp_r;
        do_reset();
        req_msg[0 +: RB]  = mk_req(1'b0, 8'hA0, 32'h1000, 2'd1, 32'h0);
        req_msg[RB +: RB] = mk_req(1'b1, 8'hB1, 32'h2000, 2'd2, 32'hDEAD);
        exp_m[0] = mk_mem(1'b0, 1'b0, 8'hA0, 32'h1000, 2'd1, 32'h0);
        exp_m[1] = mk_mem(1'b1, 1'b1, 8'hB1, 32'h2000, 2'd2, 32'hDEAD);
        req_val = 2'b11; mem_req_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_r = 2'b00; exp_r[k % 2] = 1'b1;
            checks++; if (req_rdy !== exp_r) begin
                errors++; $display("FAIL alt_rdy%0d: got %b want %b", k, req_rdy, exp_r); end
            checks++; if (mem_req_msg !== exp_m[k % 2]) begin
                errors++; $display("FAIL alt_msg%0d: got %h want %h", k, mem_req_msg, exp_m[k % 2]); end
            cyc();
        end
        #1;
        checks++; if (mem_req_val !== 1'b0) begin
            errors++; $display("FAIL alt_full: mval=%b want 0", mem_req_val); end
    endtask

    task automatic test_lock();
        logic [MB-1:0] exp0;
        do_reset();
        req_msg[0 +: RB] = mk_req(1'b0, 8'h11, 32'h100, 2'd0, 32'h5);
        exp0 = mk_mem(1'b0, 1'b0, 8'h11, 32'h100, 2'd0, 32'h5);
        req_val = 2'b01; mem_req_rdy = 1'b1;
        cyc();                                  // one transfer: ptr now favours client 1
        mem_req_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                req_msg[RB +: RB] = mk_req(1'b1, 8'h22, 32'h200, 2'd3, 32'h7);
                req_val = 2'b11;
            end
            #1;
            checks++; if (mem_req_val !== 1'b1 || mem_req_msg !== exp0 || req_rdy !== 2'b00) begin
                errors++; $display("FAIL lock_hold%0d: mval=%b msg=%h rdy=%b want 1/%h/00",
                                   c, mem_req_val, mem_req_msg, req_rdy, exp0); end
            cyc();
        end
        mem_req_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 2'b01 || mem_req_msg !== exp0) begin
            errors++; $display("FAIL lock_xfer: rdy=%b msg=%h want 01/%h", req_rdy, mem_req_msg, exp0); end
        cyc();
        req_val = 2'b10;
        #1;
        checks++; if (req_rdy !== 2'b10 ||
                      mem_req_msg !== mk_mem(1'b1, 1'b1, 8'h22, 32'h200, 2'd3, 32'h7)) begin
            errors++; $display("FAIL lock_next: rdy=%b msg=%h want 10", req_rdy, mem_req_msg); end
        cyc();
    endtask

    task automatic test_limit();
        do_reset();
        req_msg[0 +: RB] = mk_req(1'b1, 8'h05, 32'h300, 2'd1, 32'h55);
        req_val = 2'b01; mem_req_rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_rdy !== 2'b01) begin
                errors++; $display("FAIL lim_issue%0d: rdy=%b want 01", k, req_rdy); end
            cyc();
        end
        #1;
        checks++; if (req_rdy !== 2'b00 || mem_req_val !== 1'b0) begin
            errors++; $display("FAIL lim_block: rdy=%b mval=%b want 00/0", req_rdy, mem_req_val); end
        mem_resp_msg = mk_mem(1'b0, 1'b0, 8'h05, 32'h300, 2'd1, 32'hAB);
        mem_resp_val = 1'b1; resp_rdy = 2'b11;
        #1;
        checks++; if (resp_val !== 2'b01 || mem_resp_rdy !== 1'b1) begin
            errors++; $display("FAIL lim_resp: rval=%b mrdy=%b want 01/1", resp_val, mem_resp_rdy); end
        checks++; if (resp_msg !== {2{mk_req(1'b0, 8'h05, 32'h300, 2'd1, 32'hAB)}}) begin
            errors++; $display("FAIL lim_rmsg: got %h", resp_msg); end
        cyc();
        mem_resp_val = 1'b0;
        #1;
        checks++; if (req_rdy !== 2'b01 || mem_req_val !== 1'b1) begin
            errors++; $display("FAIL lim_again: rdy=%b mval=%b want 01/1", req_rdy, mem_req_val); end
        cyc();
    endtask

    task automatic test_resp_backpressure();
        do_reset();
        req_msg[RB +: RB] = mk_req(1'b0, 8'h33, 32'h400, 2'd2, 32'h9);
        req_val = 2'b10; mem_req_rdy = 1'b1;
        cyc(); cyc();
        mem_resp_msg = mk_mem(1'b1, 1'b1, 8'h33, 32'h400, 2'd2, 32'h99);
        mem_resp_val = 1'b1; resp_rdy = 2'b01;
        #1;
        checks++; if (mem_resp_rdy !== 1'b0 || resp_val !== 2'b10) begin
            errors++; $display("FAIL bp_stall: mrdy=%b rval=%b want 0/10", mem_resp_rdy, resp_val); end
        cyc();
        #1;
        checks++; if (req_rdy !== 2'b00) begin
            errors++; $display("FAIL bp_cnt_held: rdy=%b want 00", req_rdy); end
        resp_rdy = 2'b11;
        #1;
        checks++; if (mem_resp_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_go: mrdy=%b want 1", mem_resp_rdy); end
        cyc();
        mem_resp_val = 1'b0;
        #1;
        checks++; if (req_rdy !== 2'b10) begin
            errors++; $display("FAIL bp_dec: rdy=%b want 10", req_rdy); end
        cyc();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_msg[0 +: RB] = mk_req(1'b0, 8'h44, 32'h500, 2'd0, 32'h3);
        req_val = 2'b01; mem_req_rdy = 1'b1;
        cyc();                                  // client 0 count = 1
        mem_resp_msg = mk_mem(1'b0, 1'b0, 8'h44, 32'h500, 2'd0, 32'h4);
        mem_resp_val = 1'b1; resp_rdy = 2'b01;
        #1;
        checks++; if (req_rdy !== 2'b01 || mem_resp_rdy !== 1'b1) begin
            errors++; $display("FAIL b2b_both: rdy=%b mrdy=%b want 01/1", req_rdy, mem_resp_rdy); end
        cyc();
        mem_resp_val = 1'b0;
        #1;
        checks++; if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL b2b_cnt1: rdy=%b want 01", req_rdy); end
        cyc();
        #1;
        checks++; if (req_rdy !== 2'b00) begin
            errors++; $display("FAIL b2b_cnt2: rdy=%b want 00", req_rdy); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_msg[0 +: RB]  = mk_req(1'b0, 8'h55, 32'h600, 2'd1, 32'h1);
        req_msg[RB +: RB] = mk_req(1'b1, 8'h66, 32'h700, 2'd2, 32'h2);
        req_val = 2'b01; mem_req_rdy = 1'b1;
        cyc(); cyc();                           // client 0 full, ptr -> 1
        req_val = 2'b11; mem_req_rdy = 1'b0;
        #1;
        checks++; if (mem_req_msg[74] !== 1'b1) begin
            errors++; $display("FAIL mid_pre: id=%b want 1", mem_req_msg[74]); end
        cyc();                                  // lock on client 1
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req_val = 2'b00;
        mem_resp_msg = mk_mem(1'b0, 1'b0, 8'h55, 32'h600, 2'd1, 32'h1);
        mem_resp_val = 1'b1; resp_rdy = 2'b11;  // stale response, count already 0
        #1;
        checks++; if (resp_val !== 2'b01 || mem_req_val !== 1'b0) begin
            errors++; $display("FAIL mid_stale: rval=%b mval=%b want 01/0", resp_val, mem_req_val); end
        cyc();
        mem_resp_val = 1'b0;
        req_val = 2'b11; mem_req_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 2'b01) begin
            errors++; $display("FAIL mid_post: rdy=%b want 01", req_rdy); end
        cyc();
        req_val = 2'b10;
        #1;
        checks++; if (req_rdy !== 2'b10) begin
            errors++; $display("FAIL mid_cli1: rdy=%b want 10", req_rdy); end
        cyc();
    endtask

    task automatic test_random();
        int cnt [2];
        int ptr, lock_c, g, resp_k, resp_id;
        int outq [$];
        bit hold [2];
        bit resp_act, mv, xfer, rxfer;
        logic [1:0] elig, exp_r, exp_rv;
        logic [95:0] r96;
        logic [RB-1:0] m;
        logic [MB-1:0] exp_m;
        do_reset();
        cnt = '{0, 0}; hold = '{0, 0};
        ptr = 0; lock_c = -1; resp_act = 0; resp_id = 0; resp_k = 0;
        mem_resp_msg = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!hold[i]) begin
                    req_val[i] = ($urandom_range(0, 9) < 7);
                    r96 = {$urandom, $urandom, $urandom};
                    req_msg[i*RB +: RB] = r96[RB-1:0];
                end
            end
            mem_req_rdy = 1'($urandom_range(0, 1));
            if (!resp_act) begin
                if (outq.size() > 0 && $urandom_range(0, 2) != 0) begin
                    resp_k  = $urandom_range(0, outq.size() - 1);
                    resp_id = outq[resp_k];
                    r96 = {$urandom, $urandom, $urandom};
                    mem_resp_msg = {r96[75], resp_id[0], r96[73:0]};
                    mem_resp_val = 1'b1;
                end else begin
                    mem_resp_val = 1'b0;
                end
            end
            resp_rdy = 2'($urandom_range(0, 3));
            #1;
            // Reference: who should be granted this cycle.
            for (int i = 0; i < 2; i++) elig[i] = req_val[i] && (cnt[i] < 2);
            mv = 0; g = 0;
            if (lock_c >= 0) begin
                mv = 1; g = lock_c;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    if (!mv && elig[(ptr + k) % 2]) begin mv = 1; g = (ptr + k) % 2; end
                end
            end
            exp_r = 2'b00;
            if (mv && mem_req_rdy) exp_r[g] = 1'b1;
            checks++; if (mem_req_val !== mv) begin
                errors++; $display("FAIL rnd_mval n=%0d: got %b want %b", n, mem_req_val, mv); end
            checks++; if (req_rdy !== exp_r) begin
                errors++; $display("FAIL rnd_rdy n=%0d: got %b want %b", n, req_rdy, exp_r); end
            if (mv) begin
                m = req_msg[g*RB +: RB];
                exp_m = {m[74], g[0], m[73:0]};
                checks++; if (mem_req_msg !== exp_m) begin
                    errors++; $display("FAIL rnd_mmsg n=%0d: got %h want %h", n, mem_req_msg, exp_m); end
            end
            exp_rv = 2'b00;
            if (mem_resp_val) exp_rv[resp_id] = 1'b1;
            checks++; if (resp_val !== exp_rv || mem_resp_rdy !== resp_rdy[resp_id]) begin
                errors++; $display("FAIL rnd_route n=%0d: rval=%b mrdy=%b want %b/%b",
                                   n, resp_val, mem_resp_rdy, exp_rv, resp_rdy[resp_id]); end
            checks++; if (resp_msg !== {2{mem_resp_msg[75], mem_resp_msg[73:0]}}) begin
                errors++; $display("FAIL rnd_rmsg n=%0d: got %h", n, resp_msg); end
            xfer  = mv && mem_req_rdy;
            rxfer = mem_resp_val && resp_rdy[resp_id];
            cyc();
            if (xfer) begin
                cnt[g]++; ptr = (g + 1) % 2; lock_c = -1; outq.push_back(g);
            end else begin
                lock_c = mv ? g : -1;
            end
            if (rxfer) begin
                if (cnt[resp_id] > 0) cnt[resp_id]--;
                outq.delete(resp_k);
                resp_act = 0;
            end else begin
                resp_act = mem_resp_val;
            end
            for (int i = 0; i < 2; i++) hold[i] = req_val[i] && !(xfer && g == i);
        end
        req_val = '0; mem_resp_val = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_lock();
        test_limit();
        test_resp_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
